gpio_bank_irq: RTL and testbench

//  Parametrised GPIO bank for the SPI GPIO expander, a successor to the fixed 16-bit bank. APB-style slave,

---
 rtl/gpio_bank_irq_pkg.sv | 20 ++
 rtl/gpio_bank_irq_debounce.sv | 54 +++++
 rtl/gpio_bank_irq.sv | 117 +++++++++++
 tb/tb_gpio_bank_irq.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_bank_irq_pkg.sv
// Shared definitions for the GPIO bank: register map and address decode helper.
package gpio_bank_irq_pkg;

  typedef enum logic [2:0] {
    REG_DIR   = 3'd0,
    REG_OUT   = 3'd1,
    REG_IN    = 3'd2,
    REG_IE    = 3'd3,
    REG_ITYPE = 3'd4,
    REG_IPOL  = 3'd5,
    REG_ISTAT = 3'd6,
    REG_DEB   = 3'd7
  } gpio_reg_e;

  // Full-width compare so wider address buses never alias onto the 8 registers.
  function automatic logic reg_hit(input logic [31:0] addr, input gpio_reg_e r);
    return addr == 32'(r);
  endfunction

endpackage

// File: rtl/gpio_bank_irq_debounce.sv
// One GPIO pin input path: pad synchroniser, debounce counter, stable and previous-stable flops.
module gpio_debounce #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEB_WIDTH   = 4
) (
  input  logic                 sclk,
  input  logic                 resetn,
  input  logic                 pad_i,
  input  logic [DEB_WIDTH-1:0] deb_i,
  output logic                 stable_o,
  output logic                 prev_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [DEB_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   stable_q, stable_d;
  logic                   prev_q, prev_d;
  logic                   synced;
  logic [DEB_WIDTH:0]     thresh;
  logic [DEB_WIDTH:0]     cnt_inc;

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], pad_i};
    synced   = sync_q[SYNC_STAGES-1];
    // A zero threshold behaves as one; the >= compare lets a lowered threshold take effect at once.
    thresh   = (deb_i == '0) ? (DEB_WIDTH+1)'(1) : {1'b0, deb_i};
    cnt_inc  = {1'b0, cnt_q} + (DEB_WIDTH+1)'(1);
    stable_d = stable_q;
    cnt_d    = '0;
    prev_d   = stable_q;
    if (synced != stable_q) begin
      if (cnt_inc >= thresh) stable_d = synced;
      else                   cnt_d    = cnt_inc[DEB_WIDTH-1:0];
    end
  end

  always_ff @(posedge sclk or negedge resetn) begin
    if (!resetn) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      prev_q   <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      prev_q   <= prev_d;
    end
  end

  assign stable_o = stable_q;
  assign prev_o   = prev_q;

endmodule

// File: rtl/gpio_bank_irq.sv
// GPIO bank with APB-style register file, per-pin debounced inputs and edge/level interrupts.
module gpio_bank_irq
  import gpio_bank_irq_pkg::*;
#(
  parameter int unsigned PDATA_WIDTH = 8,
  parameter int unsigned PADDR_WIDTH = 3,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEB_WIDTH   = 4
) (
  input  logic                   sclk,
  input  logic                   resetn,
  input  logic                   psel,
  input  logic                   penable,
  input  logic                   pwrite,
  input  logic [PADDR_WIDTH-1:0] paddr,
  input  logic [PDATA_WIDTH-1:0] pwdata,
  output logic [PDATA_WIDTH-1:0] prdata,
  output logic                   pready,
  output logic                   pslverr,
  input  logic [PDATA_WIDTH-1:0] pad_in,
  output logic [PDATA_WIDTH-1:0] pad_out,
  output logic [PDATA_WIDTH-1:0] pad_oe,
  output logic                   irq
);

  logic [PDATA_WIDTH-1:0] dir_q, dir_d, out_q, out_d, ie_q, ie_d;
  logic [PDATA_WIDTH-1:0] itype_q, itype_d, ipol_q, ipol_d, istat_q, istat_d;
  logic [PDATA_WIDTH-1:0] prdata_q, prdata_d;
  logic [DEB_WIDTH-1:0]   deb_q, deb_d;
  logic                   irq_q, irq_d;
  logic [PDATA_WIDTH-1:0] stable, prev, rdata, w1c, edge_evt, level_evt, evt;
  logic [31:0]            addr;
  logic                   access, wr_en, setup;

  for (genvar i = 0; i < PDATA_WIDTH; i++) begin : g_pin
    gpio_debounce #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEB_WIDTH  (DEB_WIDTH)
    ) u_deb (
      .sclk    (sclk),
      .resetn  (resetn),
      .pad_i   (pad_in[i]),
      .deb_i   (deb_q),
      .stable_o(stable[i]),
      .prev_o  (prev[i])
    );
  end

  always_comb begin
    addr   = 32'(paddr);
    setup  = psel & ~penable;
    access = psel & penable;
    wr_en  = access & pwrite;

    rdata = '0;
    case (1'b1)
      reg_hit(addr, REG_DIR):   rdata = dir_q;
      reg_hit(addr, REG_OUT):   rdata = out_q;
      reg_hit(addr, REG_IN):    rdata = stable;
      reg_hit(addr, REG_IE):    rdata = ie_q;
      reg_hit(addr, REG_ITYPE): rdata = itype_q;
      reg_hit(addr, REG_IPOL):  rdata = ipol_q;
      reg_hit(addr, REG_ISTAT): rdata = istat_q;
      reg_hit(addr, REG_DEB):   rdata = PDATA_WIDTH'(deb_q);
      default:                  rdata = '0;
    endcase
    prdata_d = setup ? rdata : prdata_q;

    dir_d   = (wr_en && reg_hit(addr, REG_DIR))   ? pwdata : dir_q;
    out_d   = (wr_en && reg_hit(addr, REG_OUT))   ? pwdata : out_q;
    ie_d    = (wr_en && reg_hit(addr, REG_IE))    ? pwdata : ie_q;
    itype_d = (wr_en && reg_hit(addr, REG_ITYPE)) ? pwdata : itype_q;
    ipol_d  = (wr_en && reg_hit(addr, REG_IPOL))  ? pwdata : ipol_q;
    deb_d   = (wr_en && reg_hit(addr, REG_DEB))   ? pwdata[DEB_WIDTH-1:0] : deb_q;
    w1c     = (wr_en && reg_hit(addr, REG_ISTAT)) ? pwdata : '0;

    edge_evt  = (stable & ~prev & ipol_q) | (~stable & prev & ~ipol_q);
    level_evt = ~(stable ^ ipol_q);
    evt       = (itype_q & edge_evt) | (~itype_q & level_evt);
    // OR-ing events after the clear makes a coincident set win over W1C.
    istat_d   = (istat_q & ~w1c) | evt;
    irq_d     = |(istat_q & ie_q);
  end

  always_ff @(posedge sclk or negedge resetn) begin
    if (!resetn) begin
      dir_q    <= '0;
      out_q    <= '0;
      ie_q     <= '0;
      itype_q  <= '0;
      ipol_q   <= '0;
      istat_q  <= '0;
      deb_q    <= '0;
      prdata_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      dir_q    <= dir_d;
      out_q    <= out_d;
      ie_q     <= ie_d;
      itype_q  <= itype_d;
      ipol_q   <= ipol_d;
      istat_q  <= istat_d;
      deb_q    <= deb_d;
      prdata_q <= prdata_d;
      irq_q    <= irq_d;
    end
  end

  // Reset gating keeps the handshake low while an in-flight transfer is aborted.
  assign pready  = access & resetn;
  assign pslverr = wr_en & reg_hit(addr, REG_IN) & resetn;
  assign prdata  = prdata_q;
  assign pad_out = out_q;
  assign pad_oe  = dir_q;
  assign irq     = irq_q;

endmodule

// File: tb/tb_gpio_bank_irq.sv
// Randomised self-checking bench for gpio_bank_irq with a register/pin-level reference model.
module tb_gpio_bank_irq;

  localparam int unsigned SYNC = 2;

  logic       sclk = 1'b0;
  logic       resetn;
  logic       psel, penable, pwrite;
  logic [2:0] paddr;
  logic [7:0] pwdata, prdata, pad_in, pad_out, pad_oe;
  logic       pready, pslverr, irq;

  int checks = 0;
  int errors = 0;

  gpio_bank_irq #(
    .PDATA_WIDTH(8),
    .PADDR_WIDTH(3),
    .SYNC_STAGES(SYNC),
    .DEB_WIDTH  (4)
  ) dut (
    .sclk   (sclk),
    .resetn (resetn),
    .psel   (psel),
    .penable(penable),
    .pwrite (pwrite),
    .paddr  (paddr),
    .pwdata (pwdata),
    .prdata (prdata),
    .pready (pready),
    .pslverr(pslverr),
    .pad_in (pad_in),
    .pad_out(pad_out),
    .pad_oe (pad_oe),
    .irq    (irq)
  );

  always #5 sclk = ~sclk;

  // All tasks start and end 1ns after a rising edge.
  task automatic apb_write(input logic [2:0] a, input logic [7:0] d,
                           output logic err, output logic rdy);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    @(posedge sclk); #1;
    penable = 1'b1;
    #1;
    err = pslverr;
    rdy = pready;
    @(posedge sclk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    logic e, r;
    apb_write(a, d, e, r);
  endtask

  task automatic apb_read(input logic [2:0] a, output logic [7:0] d);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    @(posedge sclk); #1;
    penable = 1'b1;
    #1;
    d = prdata;
    @(posedge sclk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 3'd0; pwdata = 8'hFF;
    @(posedge sclk); #1;
    penable = 1'b1;
    resetn  = 1'b0;
    #1;
    checks++;
    if ({prdata, pready, pslverr, irq, pad_oe, pad_out} !== 27'h0) begin
      errors++;
      $display("FAIL reset_outputs got prdata=%h pready=%b pslverr=%b irq=%b oe=%h out=%h exp all 0",
               prdata, pready, pslverr, irq, pad_oe, pad_out);
    end
    @(posedge sclk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    resetn = 1'b1;
    @(posedge sclk); #1;
    apb_read(3'd0, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL reset_dir got %h exp 00", d); end
    apb_read(3'd7, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL reset_deb got %h exp 00", d); end
    // Default config is level-low on every pin with all pads low.
    apb_read(3'd6, d);
    checks++;
    if (d !== 8'hFF) begin errors++; $display("FAIL reset_istat_level got %h exp ff", d); end
  endtask

  task automatic test_regs();
    logic [7:0] d;
    logic e, r;
    wr(3'd0, 8'hF0);
    wr(3'd1, 8'hA5);
    @(posedge sclk); #1;
    checks++;
    if (pad_oe !== 8'hF0) begin errors++; $display("FAIL pad_oe got %h exp f0", pad_oe); end
    checks++;
    if (pad_out !== 8'hA5) begin errors++; $display("FAIL pad_out got %h exp a5", pad_out); end
    apb_read(3'd0, d);
    checks++;
    if (d !== 8'hF0) begin errors++; $display("FAIL rd_dir got %h exp f0", d); end
    apb_read(3'd1, d);
    checks++;
    if (d !== 8'hA5) begin errors++; $display("FAIL rd_out got %h exp a5", d); end
    apb_write(3'd0, 8'h3C, e, r);
    checks++;
    if ({e, r} !== 2'b01) begin errors++; $display("FAIL legal_wr got err=%b rdy=%b exp 0 1", e, r); end
    apb_write(3'd2, 8'h55, e, r);
    checks++;
    if ({e, r} !== 2'b11) begin errors++; $display("FAIL in_wr_err got err=%b rdy=%b exp 1 1", e, r); end
    apb_read(3'd2, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL in_unchanged got %h exp 00", d); end
    wr(3'd7, 8'hFF);
    apb_read(3'd7, d);
    checks++;
    if (d !== 8'h0F) begin errors++; $display("FAIL deb_width got %h exp 0f", d); end
  endtask

  task automatic test_debounce();
    logic [7:0] d;
    wr(3'd7, 8'd4);
    pad_in[0] = 1'b1;
    repeat (3) @(posedge sclk);
    #1; pad_in[0] = 1'b0;
    repeat (10) @(posedge sclk);
    #1;
    apb_read(3'd2, d);
    checks++;
    if (d[0] !== 1'b0) begin errors++; $display("FAIL glitch_reject got %b exp 0", d[0]); end
    // Just before the SYNC+DEB latency the pin must still read low.
    pad_in[0] = 1'b1;
    repeat (SYNC + 3) @(posedge sclk);
    #1;
    apb_read(3'd2, d);
    checks++;
    if (d[0] !== 1'b0) begin errors++; $display("FAIL deb_early got %b exp 0", d[0]); end
    pad_in[0] = 1'b0;
    repeat (12) @(posedge sclk);
    #1;
    pad_in[0] = 1'b1;
    repeat (SYNC + 4) @(posedge sclk);
    #1;
    apb_read(3'd2, d);
    checks++;
    if (d[0] !== 1'b1) begin errors++; $display("FAIL deb_latency got %b exp 1", d[0]); end
    pad_in[0] = 1'b0;
    repeat (12) @(posedge sclk);
    #1;
  endtask

  task automatic test_edge_irq();
    logic [7:0] d;
    wr(3'd4, 8'h01);
    wr(3'd5, 8'h01);
    wr(3'd6, 8'hFF);
    wr(3'd3, 8'h01);
    @(posedge sclk); #1;
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL edge_idle_irq got %b exp 0", irq); end
    pad_in[0] = 1'b1;
    repeat (SYNC + 5) @(posedge sclk);
    #1;
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL edge_irq_early got %b exp 0", irq); end
    @(posedge sclk); #1;
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL edge_irq_rise got %b exp 1", irq); end
    apb_read(3'd6, d);
    checks++;
    if ((d & 8'h01) !== 8'h01) begin errors++; $display("FAIL edge_istat got %h exp bit0", d); end
    wr(3'd6, 8'h01);
    @(posedge sclk); #1;
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL w1c_irq got %b exp 0", irq); end
  endtask

  task automatic test_level_set_wins();
    logic [7:0] d;
    wr(3'd4, 8'h00);
    wr(3'd5, 8'h00);
    wr(3'd6, 8'h08);
    apb_read(3'd6, d);
    checks++;
    if (d[3] !== 1'b1) begin errors++; $display("FAIL level_set_wins got %b exp 1", d[3]); end
  endtask

  task automatic test_mask();
    logic [7:0] d;
    wr(3'd4, 8'hFF);
    wr(3'd5, 8'hFF);
    wr(3'd3, 8'h00);
    wr(3'd6, 8'hFF);
    pad_in[7] = 1'b1;
    repeat (SYNC + 8) @(posedge sclk);
    #1;
    apb_read(3'd6, d);
    checks++;
    if (d !== 8'h80) begin errors++; $display("FAIL mask_istat got %h exp 80", d); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL mask_irq got %b exp 0", irq); end
    wr(3'd3, 8'h80);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL ie_irq_early got %b exp 0", irq); end
    @(posedge sclk); #1;
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL ie_irq got %b exp 1", irq); end
  endtask

  task automatic test_random();
    logic [7:0] d, newp, oldp, ipol, ie, dv, ov, exp_ist, gm;
    int unsigned deb, deb_eff, settle, len;
    int unsigned deb_tab[5] = '{0, 1, 2, 3, 5};
    oldp = pad_in;
    for (int it = 0; it < 12; it++) begin
      dv = 8'($urandom);
      ov = 8'($urandom);
      wr(3'd0, dv);
      wr(3'd1, ov);
      @(posedge sclk); #1;
      checks++;
      if ({pad_oe, pad_out} !== {dv, ov}) begin
        errors++;
        $display("FAIL rnd_pads got oe=%h out=%h exp %h %h", pad_oe, pad_out, dv, ov);
      end
      deb     = deb_tab[$urandom_range(0, 4)];
      deb_eff = (deb == 0) ? 1 : deb;
      settle  = SYNC + deb_eff + 3;
      ipol    = 8'($urandom);
      ie      = 8'($urandom);
      wr(3'd7, 8'(deb));
      wr(3'd4, 8'hFF);
      wr(3'd5, ipol);
      wr(3'd6, 8'hFF);
      wr(3'd3, ie);
      newp   = 8'($urandom);
      pad_in = newp;
      repeat (settle) @(posedge sclk);
      #1;
      exp_ist = (newp & ~oldp & ipol) | (~newp & oldp & ~ipol);
      apb_read(3'd2, d);
      checks++;
      if (d !== newp) begin errors++; $display("FAIL rnd_in got %h exp %h", d, newp); end
      apb_read(3'd6, d);
      checks++;
      if (d !== exp_ist) begin errors++; $display("FAIL rnd_istat got %h exp %h", d, exp_ist); end
      checks++;
      if (irq !== |(exp_ist & ie)) begin
        errors++;
        $display("FAIL rnd_irq got %b exp %b", irq, |(exp_ist & ie));
      end
      if (deb_eff >= 2) begin
        wr(3'd6, 8'hFF);
        gm  = 8'($urandom);
        len = $urandom_range(1, deb_eff - 1);
        pad_in = newp ^ gm;
        repeat (len) @(posedge sclk);
        #1;
        pad_in = newp;
        repeat (settle) @(posedge sclk);
        #1;
        apb_read(3'd2, d);
        checks++;
        if (d !== newp) begin errors++; $display("FAIL rnd_glitch_in got %h exp %h", d, newp); end
        apb_read(3'd6, d);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL rnd_glitch_istat got %h exp 00", d); end
      end
      oldp = newp;
    end
  endtask

  initial begin
    resetn = 1'b0;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pad_in = '0;
    repeat (2) @(posedge sclk);
    #1; resetn = 1'b1;
    @(posedge sclk); #1;
    test_reset();
    test_regs();
    test_debounce();
    test_edge_irq();
    test_level_set_wins();
    test_mask();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
